uart_fifo_bridge: RTL and testbench
===================================

Name: uart_fifo_bridge

Overview:
Buffering stage directly downstream of the buart receive side and directly upstream of its transmit side. It drains received bytes from the UART (valid/rd handshake) into an RX FIFO. It feeds bytes from a TX FIFO into the UART (wr strobe, gated by busy). The host side (j1a I/O decode) sees two byte-wide FIFOs with push/pop strobes, so the CPU never polls the UART at character rate.

Parameters:
DEPTH_LOG2, 4, log2 of each FIFO depth (depth = 16 entries); each FIFO has its own storage.

Ports:
clk  in  1  master clock, shared with buart
resetq  in  1  asynchronous reset, active low
uart_valid  in  1  buart valid
uart_rx_data  in  8  buart rx_data
uart_rd  out  1  read strobe to buart, clears its valid
uart_busy  in  1  buart busy
uart_wr  out  1  write strobe to buart
uart_tx_data  out  8  byte to buart tx_data
rx_pop  in  1  host consumes RX head
rx_data  out  8  RX FIFO head (first-word fall-through)
rx_empty  out  1  RX FIFO empty
tx_push  in  1  host writes tx_wdata
tx_wdata  in  8  byte to enqueue
tx_full  out  1  TX FIFO full

Behaviour:
- Reset (resetq low, async): both FIFO pointers/counts = 0, rx_empty = 1, tx_full = 0, uart_rd = 0, uart_wr = 0, uart_tx_data = 8'h00, TX FSM = IDLE. FIFO storage is not reset.
- FIFOs: circular, pointers DEPTH_LOG2 bits with natural wrap. Count is DEPTH_LOG2+1 bits. Full when count == 2**DEPTH_LOG2; empty when count == 0.
- FIFO boundary rules:
  - Push when full: ignored.
  - Pop when empty: ignored.
  - Simultaneous push and pop on a non-empty, non-full FIFO: both happen, count unchanged.
  - Push and pop together on an empty FIFO: the push happens, the pop is ignored.
  - Push and pop together on a full FIFO: the pop happens, the push is ignored.
- rx_data = storage[rd_ptr], combinational. It is meaningful only while rx_empty = 0.
- RX drain:
  - Push condition: uart_valid & ~uart_rd & ~rx_full. On a push, uart_rx_data is written into the RX FIFO and uart_rd is registered high for exactly one cycle.
  - The ~uart_rd term blocks a double push. buart only drops valid at the edge that ends the uart_rd cycle.
  - When the RX FIFO is full, no rd is issued and the byte waits in buart. If buart receives another byte meanwhile, it overwrites; this loss is accepted.
  - Latency: uart_valid rising to the byte appearing on rx_data (rx_empty low) = 1 clk.
- TX FSM (registered outputs):
  - IDLE: if ~tx_empty & ~uart_busy, then uart_tx_data <= head, pop TX FIFO, uart_wr <= 1, go to LOAD. Otherwise stay.
  - LOAD: uart_wr <= 0, go to WAIT_BUSY.
  - WAIT_BUSY: when uart_busy = 1, go to WAIT_DONE. buart raises busy two edges after the wr edge.
  - WAIT_DONE: when uart_busy = 0, go to IDLE.
  - uart_wr is high for exactly one clk per byte. Consecutive bytes are separated by the full frame time plus at most 3 clk.
- Reset mid-operation: the bridge returns to IDLE, but buart is not reset and may still be sending. IDLE's ~uart_busy gate guarantees no frame is clobbered. Bytes in flight in the FIFOs are discarded.
- tx_push during uart_wr: independent of the drain. The FIFO rules above apply.

Optional Feature:
Macro UART_FIFO_BRIDGE_STATUS_EN.
- Defined: adds output ports rx_level and tx_level, each DEPTH_LOG2+1 bits. They equal the current FIFO counts, registered alongside the pointers, reset to 0. Adds output rx_full (1 bit), giving the host overrun visibility.
- Undefined: these ports and their logic are absent. rx_full remains internal.

Test Plan:
- RX single byte: pulse uart_valid with uart_rx_data = 8'hA5; the model drops valid on rd. Required: uart_rd is high for exactly 1 clk, then rx_empty = 0 and rx_data = 8'hA5. rx_pop -> rx_empty = 1.
- RX fill/overflow, DEPTH_LOG2 = 2: present 5 bytes 8'h01..8'h05. Required: 4 rd strobes, and uart_valid stays high for byte 8'h05 with no rd. One rx_pop yields 8'h01, after which byte 8'h05 is drained within 2 clk.
- TX burst: push 8'h48, 8'h69, 8'h0A with a buart busy model of 40 clk. Required: three single-cycle uart_wr pulses carrying those bytes in order, each issued only after busy has fallen. tx_full stays 0.
- TX full: DEPTH_LOG2 = 2, busy held high, push 5 bytes. Required: tx_full = 1 after the 4th push; the 5th byte is dropped; no uart_wr until busy falls.
- Simultaneous push and pop on the RX FIFO at count = 2: count remains 2 and data order is preserved. Pointer wrap: 20 sequential bytes pass through intact.
- Async reset mid-frame: assert resetq low while in WAIT_DONE with 3 bytes queued. Required: immediate rx_empty = 1 and uart_wr = 0. After release, no uart_wr while busy = 1.

Source files
------------

// File: rtl/uart_fifo_bridge.sv
// Byte FIFOs between the buart and the j1a I/O decode: RX drain into a FIFO, TX FIFO feeding the UART.
// Define UART_FIFO_BRIDGE_STATUS_EN to expose rx_level, tx_level and rx_full to the host.
module uart_fifo_bridge #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  resetq,
    input  logic                  uart_valid,
    input  logic [7:0]            uart_rx_data,
    output logic                  uart_rd,
    input  logic                  uart_busy,
    output logic                  uart_wr,
    output logic [7:0]            uart_tx_data,
    input  logic                  rx_pop,
    output logic [7:0]            rx_data,
    output logic                  rx_empty,
    input  logic                  tx_push,
    input  logic [7:0]            tx_wdata,
    output logic                  tx_full
`ifdef UART_FIFO_BRIDGE_STATUS_EN
    ,
    output logic [DEPTH_LOG2:0]   rx_level,
    output logic [DEPTH_LOG2:0]   tx_level,
    output logic                  rx_full
`endif
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_BUSY,
        WAIT_DONE
    } tx_state_t;

    logic [7:0]            rx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rx_wr_ptr;
    logic [DEPTH_LOG2-1:0] rx_rd_ptr;
    logic [CW-1:0]         rx_count;
    logic                  rx_full_int;
    logic                  rx_push_c;
    logic                  rx_pop_c;

    logic [7:0]            tx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] tx_wr_ptr;
    logic [DEPTH_LOG2-1:0] tx_rd_ptr;
    logic [CW-1:0]         tx_count;
    logic                  tx_empty;
    logic                  tx_push_c;
    logic                  tx_pop_c;

    tx_state_t             state;
    tx_state_t             state_next;
    logic                  wr_next;
    logic [7:0]            tx_data_next;

    assign rx_full_int = (rx_count == CW'(DEPTH));
    assign rx_empty    = (rx_count == CW'(0));
    assign tx_full     = (tx_count == CW'(DEPTH));
    assign tx_empty    = (tx_count == CW'(0));
    assign rx_data     = rx_mem[rx_rd_ptr];

    // ~uart_rd holds off the second push while buart is still clearing valid
    assign rx_push_c = uart_valid & ~uart_rd & ~rx_full_int;
    assign rx_pop_c  = rx_pop & ~rx_empty;
    assign tx_push_c = tx_push & ~tx_full;

`ifdef UART_FIFO_BRIDGE_STATUS_EN
    assign rx_level = rx_count;
    assign tx_level = tx_count;
    assign rx_full  = rx_full_int;
`endif

    // FIFO storage, intentionally not reset
    always_ff @(posedge clk) begin
        if (rx_push_c) begin
            rx_mem[rx_wr_ptr] <= uart_rx_data;
        end
        if (tx_push_c) begin
            tx_mem[tx_wr_ptr] <= tx_wdata;
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
            uart_rd   <= 1'b0;
        end else begin
            uart_rd <= rx_push_c;
            if (rx_push_c) begin
                rx_wr_ptr <= rx_wr_ptr + 1'b1;
            end
            if (rx_pop_c) begin
                rx_rd_ptr <= rx_rd_ptr + 1'b1;
            end
            case ({rx_push_c, rx_pop_c})
                2'b10:   rx_count <= rx_count + CW'(1);
                2'b01:   rx_count <= rx_count - CW'(1);
                default: rx_count <= rx_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push_c) begin
                tx_wr_ptr <= tx_wr_ptr + 1'b1;
            end
            if (tx_pop_c) begin
                tx_rd_ptr <= tx_rd_ptr + 1'b1;
            end
            case ({tx_push_c, tx_pop_c})
                2'b10:   tx_count <= tx_count + CW'(1);
                2'b01:   tx_count <= tx_count - CW'(1);
                default: tx_count <= tx_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state        <= IDLE;
            uart_wr      <= 1'b0;
            uart_tx_data <= 8'h00;
        end else begin
            state        <= state_next;
            uart_wr      <= wr_next;
            uart_tx_data <= tx_data_next;
        end
    end

    // IDLE waits on ~uart_busy so a frame left running across a bridge reset is never clobbered
    always_comb begin
        state_next   = state;
        wr_next      = 1'b0;
        tx_data_next = uart_tx_data;
        tx_pop_c     = 1'b0;
        case (state)
            IDLE: begin
                if (!tx_empty && !uart_busy) begin
                    tx_data_next = tx_mem[tx_rd_ptr];
                    tx_pop_c     = 1'b1;
                    wr_next      = 1'b1;
                    state_next   = LOAD;
                end
            end
            LOAD: begin
                state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (uart_busy) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!uart_busy) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Directed bench for uart_fifo_bridge (DEPTH_LOG2 = 2) with small buart rx/tx behavioural models.
`timescale 1ns/1ps
module tb_uart_fifo_bridge;

    logic       clk = 1'b0;
    logic       resetq = 1'b0;
    logic       uart_valid = 1'b0;
    logic [7:0] uart_rx_data = 8'h00;
    logic       uart_rd;
    wire        uart_busy;
    logic       uart_wr;
    logic [7:0] uart_tx_data;
    logic       rx_pop = 1'b0;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic       tx_push = 1'b0;
    logic [7:0] tx_wdata = 8'h00;
    logic       tx_full;

    logic       model_busy = 1'b0;
    logic       hold_busy = 1'b0;
    logic       pend = 1'b0;
    logic       wr_prev = 1'b0;
    int         frame = 0;
    int         wr_bad = 0;
    logic [7:0] rx_q[$];
    logic [7:0] tx_log[$];

    int checks = 0;
    int passed = 0;

    assign uart_busy = model_busy | hold_busy;

    always #5 clk = ~clk;

    uart_fifo_bridge #(.DEPTH_LOG2(2)) dut (
        .clk          (clk),
        .resetq       (resetq),
        .uart_valid   (uart_valid),
        .uart_rx_data (uart_rx_data),
        .uart_rd      (uart_rd),
        .uart_busy    (uart_busy),
        .uart_wr      (uart_wr),
        .uart_tx_data (uart_tx_data),
        .rx_pop       (rx_pop),
        .rx_data      (rx_data),
        .rx_empty     (rx_empty),
        .tx_push      (tx_push),
        .tx_wdata     (tx_wdata),
        .tx_full      (tx_full)
    );

    // buart receive side: holds valid until the edge that ends the rd cycle
    always @(posedge clk) begin
        if (uart_rd) begin
            uart_valid <= 1'b0;
        end else if (!uart_valid && rx_q.size() > 0) begin
            uart_valid   <= 1'b1;
            uart_rx_data <= rx_q.pop_front();
        end
    end

    // buart transmit side: busy rises two edges after the wr edge, 40 clk frame
    always @(posedge clk) begin
        wr_prev <= uart_wr;
        if (uart_wr) begin
            tx_log.push_back(uart_tx_data);
            if (uart_busy || wr_prev) wr_bad <= wr_bad + 1;
        end
        if (pend) begin
            pend       <= 1'b0;
            model_busy <= 1'b1;
            frame      <= 40;
        end else if (frame > 0) begin
            frame <= frame - 1;
            if (frame == 1) model_busy <= 1'b0;
        end
        if (uart_wr) pend <= 1'b1;
    end

    task automatic pop_byte(output logic [7:0] b);
        b = rx_data;
        rx_pop = 1'b1;
        @(negedge clk);
        rx_pop = 1'b0;
    endtask

    task automatic push_tx(input logic [7:0] b);
        tx_wdata = b;
        tx_push = 1'b1;
        @(negedge clk);
        tx_push = 1'b0;
    endtask

    function automatic logic [7:0] log_at(input int idx);
        if (idx < tx_log.size()) return tx_log[idx];
        return 8'hxx;
    endfunction

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (rx_empty !== 1'b1) $display("FAIL reset_rx_empty got %b want 1", rx_empty); else passed++;
        checks++; if (tx_full !== 1'b0) $display("FAIL reset_tx_full got %b want 0", tx_full); else passed++;
        checks++; if (uart_rd !== 1'b0) $display("FAIL reset_uart_rd got %b want 0", uart_rd); else passed++;
        checks++; if (uart_wr !== 1'b0) $display("FAIL reset_uart_wr got %b want 0", uart_wr); else passed++;
        checks++; if (uart_tx_data !== 8'h00) $display("FAIL reset_tx_data got %h want 00", uart_tx_data); else passed++;
        resetq = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_rx_single;
        int n = 0;
        int rd_more = 0;
        logic [7:0] b;
        rx_q.push_back(8'hA5);
        while (!uart_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (uart_valid !== 1'b1) $display("FAIL rx1_valid_timeout got %b want 1", uart_valid); else passed++;
        checks++; if (rx_empty !== 1'b1) $display("FAIL rx1_empty_before got %b want 1", rx_empty); else passed++;
        @(negedge clk);
        checks++; if (rx_empty !== 1'b0) $display("FAIL rx1_latency_empty got %b want 0", rx_empty); else passed++;
        checks++; if (uart_rd !== 1'b1) $display("FAIL rx1_rd got %b want 1", uart_rd); else passed++;
        repeat (5) begin
            @(negedge clk);
            if (uart_rd) rd_more++;
        end
        checks++; if (rd_more !== 0) $display("FAIL rx1_rd_width extra rd cycles %0d want 0", rd_more); else passed++;
        checks++; if (rx_data !== 8'hA5) $display("FAIL rx1_data got %h want a5", rx_data); else passed++;
        checks++; if (uart_valid !== 1'b0) $display("FAIL rx1_valid_cleared got %b want 0", uart_valid); else passed++;
        pop_byte(b);
        checks++; if (rx_empty !== 1'b1) $display("FAIL rx1_empty_after_pop got %b want 1", rx_empty); else passed++;
    endtask

    task automatic test_rx_overflow;
        int rd_cnt = 0;
        int n = 0;
        logic [7:0] b;
        for (int i = 1; i <= 5; i++) rx_q.push_back(8'(i));
        repeat (40) begin
            @(negedge clk);
            if (uart_rd) rd_cnt++;
        end
        checks++; if (rd_cnt !== 4) $display("FAIL rxovf_rd_count got %0d want 4", rd_cnt); else passed++;
        checks++; if (uart_valid !== 1'b1) $display("FAIL rxovf_valid_waiting got %b want 1", uart_valid); else passed++;
        checks++; if (uart_rx_data !== 8'h05) $display("FAIL rxovf_waiting_byte got %h want 05", uart_rx_data); else passed++;
        pop_byte(b);
        checks++; if (b !== 8'h01) $display("FAIL rxovf_first_pop got %h want 01", b); else passed++;
        while (!uart_rd && n < 2) begin
            @(negedge clk);
            n++;
        end
        checks++; if (uart_rd !== 1'b1) $display("FAIL rxovf_drain_2clk got rd=%b after %0d clk want 1", uart_rd, n); else passed++;
        @(negedge clk);
        for (int i = 2; i <= 5; i++) begin
            pop_byte(b);
            checks++; if (b !== 8'(i)) $display("FAIL rxovf_order got %h want %h", b, 8'(i)); else passed++;
        end
        checks++; if (rx_empty !== 1'b1) $display("FAIL rxovf_empty_end got %b want 1", rx_empty); else passed++;
    endtask

    task automatic test_tx_burst;
        int base = tx_log.size();
        int bad0 = wr_bad;
        int n = 0;
        logic full_seen = 1'b0;
        logic [7:0] exp [3] = '{8'h48, 8'h69, 8'h0A};
        for (int i = 0; i < 3; i++) begin
            push_tx(exp[i]);
            if (tx_full) full_seen = 1'b1;
        end
        while (tx_log.size() < base + 3 && n < 400) begin
            @(negedge clk);
            if (tx_full) full_seen = 1'b1;
            n++;
        end
        checks++; if (tx_log.size() !== base + 3) $display("FAIL txb_wr_count got %0d want 3", tx_log.size() - base); else passed++;
        for (int i = 0; i < 3; i++) begin
            checks++; if (log_at(base + i) !== exp[i]) $display("FAIL txb_byte%0d got %h want %h", i, log_at(base + i), exp[i]); else passed++;
        end
        checks++; if (wr_bad !== bad0) $display("FAIL txb_wr_protocol got %0d violations want 0", wr_bad - bad0); else passed++;
        checks++; if (full_seen !== 1'b0) $display("FAIL txb_tx_full got %b want 0", full_seen); else passed++;
        repeat (60) @(negedge clk);
    endtask

    task automatic test_tx_full;
        int base;
        int bad0 = wr_bad;
        int n = 0;
        hold_busy = 1'b1;
        @(negedge clk);
        base = tx_log.size();
        push_tx(8'h11);
        push_tx(8'h22);
        push_tx(8'h33);
        checks++; if (tx_full !== 1'b0) $display("FAIL txf_full_at3 got %b want 0", tx_full); else passed++;
        push_tx(8'h44);
        checks++; if (tx_full !== 1'b1) $display("FAIL txf_full_at4 got %b want 1", tx_full); else passed++;
        push_tx(8'h55);
        checks++; if (tx_full !== 1'b1) $display("FAIL txf_full_at5 got %b want 1", tx_full); else passed++;
        repeat (20) @(negedge clk);
        checks++; if (tx_log.size() !== base) $display("FAIL txf_wr_while_busy got %0d writes want 0", tx_log.size() - base); else passed++;
        hold_busy = 1'b0;
        while (tx_log.size() < base + 4 && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (60) @(negedge clk);
        checks++; if (tx_log.size() !== base + 4) $display("FAIL txf_wr_count got %0d want 4", tx_log.size() - base); else passed++;
        for (int i = 0; i < 4; i++) begin
            checks++; if (log_at(base + i) !== 8'(8'h11 * (i + 1))) $display("FAIL txf_byte%0d got %h want %h", i, log_at(base + i), 8'(8'h11 * (i + 1))); else passed++;
        end
        checks++; if (tx_full !== 1'b0) $display("FAIL txf_full_drained got %b want 0", tx_full); else passed++;
        checks++; if (wr_bad !== bad0) $display("FAIL txf_wr_protocol got %0d violations want 0", wr_bad - bad0); else passed++;
    endtask

    task automatic test_rx_simul_push_pop;
        int n = 0;
        logic [7:0] b;
        rx_q.push_back(8'hC1);
        rx_q.push_back(8'hC2);
        repeat (12) @(negedge clk);
        checks++; if (rx_empty !== 1'b0) $display("FAIL sim_prefill_empty got %b want 0", rx_empty); else passed++;
        rx_q.push_back(8'hC3);
        while (!(uart_valid && !uart_rd) && n < 20) begin
            @(negedge clk);
            n++;
        end
        pop_byte(b);
        checks++; if (b !== 8'hC1) $display("FAIL sim_pop1 got %h want c1", b); else passed++;
        checks++; if (uart_rd !== 1'b1) $display("FAIL sim_push_same_edge got rd=%b want 1", uart_rd); else passed++;
        @(negedge clk);
        pop_byte(b);
        checks++; if (b !== 8'hC2) $display("FAIL sim_pop2 got %h want c2", b); else passed++;
        checks++; if (rx_empty !== 1'b0) $display("FAIL sim_count_kept got empty=%b want 0", rx_empty); else passed++;
        pop_byte(b);
        checks++; if (b !== 8'hC3) $display("FAIL sim_pop3 got %h want c3", b); else passed++;
        checks++; if (rx_empty !== 1'b1) $display("FAIL sim_empty_end got %b want 1", rx_empty); else passed++;
    endtask

    task automatic test_wrap;
        int idx = 0;
        int n = 0;
        for (int i = 0; i < 20; i++) rx_q.push_back(8'(8'h30 + i));
        while (idx < 20 && n < 300) begin
            @(negedge clk);
            rx_pop = 1'b0;
            if (!rx_empty) begin
                checks++; if (rx_data !== 8'(8'h30 + idx)) $display("FAIL wrap_byte%0d got %h want %h", idx, rx_data, 8'(8'h30 + idx)); else passed++;
                idx++;
                rx_pop = 1'b1;
            end
            n++;
        end
        @(negedge clk);
        rx_pop = 1'b0;
        @(negedge clk);
        checks++; if (idx !== 20) $display("FAIL wrap_count got %0d want 20", idx); else passed++;
        checks++; if (rx_empty !== 1'b1) $display("FAIL wrap_empty_end got %b want 1", rx_empty); else passed++;
    endtask

    task automatic test_async_reset;
        int base;
        int bad0 = wr_bad;
        int n = 0;
        rx_q.push_back(8'hD1);
        rx_q.push_back(8'hD2);
        repeat (8) @(negedge clk);
        push_tx(8'hA1);
        push_tx(8'hA2);
        push_tx(8'hA3);
        push_tx(8'hA4);
        while (!uart_busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        base = tx_log.size();
        checks++; if (rx_empty !== 1'b0) $display("FAIL rst_rx_pre got empty=%b want 0", rx_empty); else passed++;
        checks++; if (uart_busy !== 1'b1) $display("FAIL rst_busy_pre got %b want 1", uart_busy); else passed++;
        #2 resetq = 1'b0;
        #1;
        checks++; if (rx_empty !== 1'b1) $display("FAIL rst_rx_empty got %b want 1", rx_empty); else passed++;
        checks++; if (uart_wr !== 1'b0) $display("FAIL rst_uart_wr got %b want 0", uart_wr); else passed++;
        checks++; if (uart_tx_data !== 8'h00) $display("FAIL rst_tx_data got %h want 00", uart_tx_data); else passed++;
        @(negedge clk);
        resetq = 1'b1;
        push_tx(8'h5A);
        repeat (5) @(negedge clk);
        checks++; if (tx_log.size() !== base) $display("FAIL rst_wr_while_busy got %0d writes want 0", tx_log.size() - base); else passed++;
        n = 0;
        while (tx_log.size() < base + 1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (60) @(negedge clk);
        checks++; if (tx_log.size() !== base + 1) $display("FAIL rst_wr_count got %0d want 1", tx_log.size() - base); else passed++;
        checks++; if (log_at(base) !== 8'h5A) $display("FAIL rst_byte got %h want 5a", log_at(base)); else passed++;
        checks++; if (wr_bad !== bad0) $display("FAIL rst_wr_protocol got %0d violations want 0", wr_bad - bad0); else passed++;
    endtask

    initial begin
        test_reset();
        test_rx_single();
        test_rx_overflow();
        test_tx_burst();
        test_tx_full();
        test_rx_simul_push_pop();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete, passed %0d of %0d so far", passed, checks);
        $fatal(1, "watchdog");
    end

endmodule
